// File: rtl/xge_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xge_pkt_pkg
// Description : Shared packet-domain defaults and arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package xge_pkt_pkg;

    localparam int PKT_DATA_W = 64;
    localparam int PKT_MOD_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb
// Description : Combinational round-robin pick. Returns the first requester
//               at or after the pointer (wrapping) as one-hot, index and any.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // Scan offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin : p_pick
        int             v_sum;
        logic [IDX_W-1:0] v_idx;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        v_sum = 0;
        v_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            v_sum = int'(i_ptr) + i;
            if (v_sum >= NUM_CH) begin
                v_sum = v_sum - NUM_CH;
            end
            v_idx = IDX_W'(v_sum);
            if (i_req[v_idx]) begin
                o_gnt        = '0;
                o_gnt[v_idx] = 1'b1;
                o_idx        = v_idx;
                o_any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : pkt_tx_arb
// Description : Round-robin packet arbiter merging NUM_CH packet channels onto
//               one MAC transmit stream. Whole packets only; one arbitration
//               cycle between packets; sticky per-channel framing errors.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_tx_arb
    import xge_pkt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = PKT_DATA_W,
    parameter int MOD_W  = $clog2(DATA_W / 8)
) (
    input  logic                       clk_156m25,
    input  logic                       reset_156m25,
    input  logic [NUM_CH-1:0]          in_val,
    input  logic [NUM_CH-1:0]          in_sop,
    input  logic [NUM_CH-1:0]          in_eop,
    input  logic [NUM_CH*MOD_W-1:0]    in_mod,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_rdy,
    output logic [DATA_W-1:0]          pkt_tx_data,
    output logic                       pkt_tx_val,
    output logic                       pkt_tx_sop,
    output logic                       pkt_tx_eop,
    output logic [MOD_W-1:0]           pkt_tx_mod,
    input  logic                       pkt_tx_full,
    input  logic                       err_clr,
    output logic [NUM_CH-1:0]          err_sticky,
    output logic [$clog2(NUM_CH)-1:0]  cur_ch,
    output logic                       busy
);

    localparam int              CH_W      = $clog2(NUM_CH);
    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(NUM_CH - 1);

    arb_state_t        r_state;
    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_cur_ch;
    logic [NUM_CH-1:0] r_own_oh;
    logic              r_first;
    logic              r_busy;
    logic [NUM_CH-1:0] r_err;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_gnt_any;

    logic              w_own_val;
    logic              w_own_sop;
    logic              w_own_eop;
    logic [MOD_W-1:0]  w_own_mod;
    logic [DATA_W-1:0] w_own_data;
    logic              w_xfer;
    logic [NUM_CH-1:0] w_stray;
    logic [NUM_CH-1:0] w_err_set;

    // Only a word carrying sop can open a packet.
    assign w_req = in_val & in_sop;

    rr_arb #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_rr_arb (
        .i_req (w_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    // Word presented by the channel that currently owns the output.
    assign w_own_val  = in_val[r_cur_ch];
    assign w_own_sop  = in_sop[r_cur_ch];
    assign w_own_eop  = in_eop[r_cur_ch];
    assign w_own_mod  = in_mod[int'(r_cur_ch) * MOD_W +: MOD_W];
    assign w_own_data = in_data[int'(r_cur_ch) * DATA_W +: DATA_W];

    assign w_xfer  = (r_state == XFER) && w_own_val && !pkt_tx_full;

    // Between packets, any non-sop word is orphaned and gets swallowed.
    assign w_stray = (r_state == IDLE) ? (in_val & ~in_sop) : '0;

    // Framing errors: orphaned words, or a fresh sop inside an open packet.
    assign w_err_set = w_stray |
                       ((w_xfer && w_own_sop && !r_first) ? r_own_oh : '0);

    // Accept strays while idle, otherwise only the owner when the MAC has room.
    always_comb begin
        in_rdy = '0;
        if (!reset_156m25) begin
            if (r_state == IDLE) begin
                in_rdy = w_stray;
            end else if (!pkt_tx_full) begin
                in_rdy = r_own_oh;
            end
        end
    end

    // Arbitration FSM: grant in IDLE, hold ownership until the eop word moves.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_cur_ch <= '0;
            r_own_oh <= '0;
            r_first  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_any) begin
                        r_state  <= XFER;
                        r_busy   <= 1'b1;
                        r_cur_ch <= w_gnt_idx;
                        r_own_oh <= w_gnt;
                        r_first  <= 1'b1;
                    end
                end
                XFER: begin
                    if (w_xfer) begin
                        r_first <= 1'b0;
                        if (w_own_eop) begin
                            r_state  <= IDLE;
                            r_busy   <= 1'b0;
                            r_rr_ptr <= (r_cur_ch == C_LAST_CH) ? '0
                                                                : r_cur_ch + CH_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear survives.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            r_err <= '0;
        end else begin
            r_err <= (r_err & ~{NUM_CH{err_clr}}) | w_err_set;
        end
    end

    // Registered transmit stream; sideband fields are zero on idle cycles.
    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            pkt_tx_val  <= 1'b0;
            pkt_tx_sop  <= 1'b0;
            pkt_tx_eop  <= 1'b0;
            pkt_tx_mod  <= '0;
            pkt_tx_data <= '0;
        end else begin
            pkt_tx_val <= w_xfer;
            if (w_xfer) begin
                pkt_tx_sop  <= w_own_sop;
                pkt_tx_eop  <= w_own_eop;
                pkt_tx_mod  <= w_own_eop ? w_own_mod : '0;
                pkt_tx_data <= w_own_data;
            end else begin
                pkt_tx_sop  <= 1'b0;
                pkt_tx_eop  <= 1'b0;
                pkt_tx_mod  <= '0;
                pkt_tx_data <= '0;
            end
        end
    end

    assign err_sticky = r_err;
    assign cur_ch     = r_cur_ch;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_tx_arb
// Description : Self-checking bench for pkt_tx_arb. Per-channel packet queues
//               feed the DUT; a round-robin packet-order model predicts the
//               merged stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_tx_arb;
    import xge_pkt_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = PKT_DATA_W;
    localparam int MW  = PKT_MOD_W;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [MW-1:0] mod;
        logic [1:0]    ch;
    } word_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_val, in_sop, in_eop, in_rdy;
    logic [NCH*MW-1:0] in_mod;
    logic [NCH*DW-1:0] in_data;
    logic [DW-1:0]     pkt_tx_data;
    logic              pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
    logic [MW-1:0]     pkt_tx_mod;
    logic              pkt_tx_full;
    logic              err_clr;
    logic [NCH-1:0]    err_sticky;
    logic [1:0]        cur_ch;
    logic              busy;

    pkt_tx_arb #(.NUM_CH(NCH), .DATA_W(DW), .MOD_W(MW)) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .in_val       (in_val),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_mod       (in_mod),
        .in_data      (in_data),
        .in_rdy       (in_rdy),
        .pkt_tx_data  (pkt_tx_data),
        .pkt_tx_val   (pkt_tx_val),
        .pkt_tx_sop   (pkt_tx_sop),
        .pkt_tx_eop   (pkt_tx_eop),
        .pkt_tx_mod   (pkt_tx_mod),
        .pkt_tx_full  (pkt_tx_full),
        .err_clr      (err_clr),
        .err_sticky   (err_sticky),
        .cur_ch       (cur_ch),
        .busy         (busy)
    );

    initial forever #5 clk = ~clk;

    word_t          src_q [NCH][$];
    word_t          exp_q [$];
    int             n_total  = 0;
    int             n_bad    = 0;
    int             cyc_cnt  = 0;
    int             first_out = -1;
    int             last_eop  = -1;
    int             m_ptr    = 0;
    bit             gap_en   = 1'b0;
    logic [NCH-1:0] samp_rdy;
    logic           full_now;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending_src();
        int s = 0;
        for (int c = 0; c < NCH; c++) s += src_q[c].size();
        return s;
    endfunction

    task automatic drive();
        for (int c = 0; c < NCH; c++) begin
            if (src_q[c].size() > 0) begin
                word_t w;
                w = src_q[c][0];
                in_val[c]            = 1'b1;
                in_sop[c]            = w.sop;
                in_eop[c]            = w.eop;
                in_mod[c*MW +: MW]   = w.mod;
                in_data[c*DW +: DW]  = w.data;
            end else begin
                in_val[c]            = 1'b0;
                in_sop[c]            = 1'b0;
                in_eop[c]            = 1'b0;
                in_mod[c*MW +: MW]   = '0;
                in_data[c*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic push_pkt(input int ch, input int len, input int eop_mod);
        for (int i = 0; i < len; i++) begin
            word_t w;
            w.data = {$urandom, $urandom};
            w.sop  = (i == 0);
            w.eop  = (i == len - 1);
            w.mod  = (i == len - 1) ? MW'(eop_mod) : MW'($urandom);
            w.ch   = 2'(ch);
            src_q[ch].push_back(w);
        end
    endtask

    task automatic push_stray(input int ch);
        word_t w;
        w.data = {$urandom, $urandom};
        w.sop  = 1'b0;
        w.eop  = 1'b0;
        w.mod  = MW'($urandom);
        w.ch   = 2'(ch);
        src_q[ch].push_back(w);
    endtask

    // Model: whole packets leave in round-robin order from the pointer,
    // the pointer moving past each channel that completes a packet.
    task automatic build_expected();
        int    idx [NCH];
        int    sel;
        bit    more;
        bit    eop_seen;
        word_t w;
        for (int c = 0; c < NCH; c++) idx[c] = 0;
        more = 1'b1;
        while (more) begin
            sel = -1;
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_ptr + k) % NCH;
                if (sel < 0 && idx[c] < src_q[c].size()) sel = c;
            end
            if (sel < 0) begin
                more = 1'b0;
            end else begin
                eop_seen = 1'b0;
                while (!eop_seen && idx[sel] < src_q[sel].size()) begin
                    w = src_q[sel][idx[sel]];
                    idx[sel]++;
                    eop_seen = w.eop;
                    if (!w.eop) w.mod = '0;
                    exp_q.push_back(w);
                end
                m_ptr = (sel + 1) % NCH;
            end
        end
    endtask

    // One clock: sample handshakes mid-cycle, check the stream after the edge.
    task automatic cyc();
        logic [NCH-1:0] acc;
        word_t          e;
        word_t          dummy;
        @(negedge clk);
        acc      = in_val & in_rdy;
        samp_rdy = in_rdy;
        full_now = pkt_tx_full;
        @(posedge clk);
        #1;
        cyc_cnt++;
        if (full_now) chk("stall_val", DW'(pkt_tx_val), 0);
        if (pkt_tx_val === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("extra_word", DW'(pkt_tx_val), 0);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data", pkt_tx_data, e.data);
                chk("tx_sop", DW'(pkt_tx_sop), DW'(e.sop));
                chk("tx_eop", DW'(pkt_tx_eop), DW'(e.eop));
                chk("tx_mod", DW'(pkt_tx_mod), DW'(e.mod));
                chk("tx_cur_ch", DW'(cur_ch), DW'(e.ch));
                if (first_out < 0) first_out = cyc_cnt;
                if (gap_en && pkt_tx_sop && last_eop >= 0)
                    chk("pkt_gap", DW'(cyc_cnt - last_eop), 2);
                if (pkt_tx_eop) last_eop = cyc_cnt;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (acc[c] && src_q[c].size() > 0) dummy = src_q[c].pop_front();
        end
        drive();
    endtask

    task automatic run_done(input int bound, input bit rfull);
        int n = 0;
        while ((exp_q.size() > 0 || pending_src() > 0) && n < bound) begin
            pkt_tx_full = rfull ? ($urandom_range(0, 3) == 0) : 1'b0;
            cyc();
            n++;
        end
        pkt_tx_full = 1'b0;
        cyc();
        cyc();
        chk("drained", DW'(exp_q.size() + pending_src()), 0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_val"},  DW'(pkt_tx_val), 0);
        chk({tag, "_sop"},  DW'(pkt_tx_sop), 0);
        chk({tag, "_eop"},  DW'(pkt_tx_eop), 0);
        chk({tag, "_mod"},  DW'(pkt_tx_mod), 0);
        chk({tag, "_data"}, pkt_tx_data, 0);
        chk({tag, "_busy"}, DW'(busy), 0);
        chk({tag, "_cur"},  DW'(cur_ch), 0);
        chk({tag, "_rdy"},  DW'(in_rdy), 0);
        chk({tag, "_err"},  DW'(err_sticky), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        drive();
    endtask

    initial begin
        int t0;
        word_t w;
        rst = 1'b0; pkt_tx_full = 1'b0; err_clr = 1'b0;
        in_val = '0; in_sop = '0; in_eop = '0; in_mod = '0; in_data = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;
        drive();

        // Ch1 three-word packet, mod 5 on eop.
        push_pkt(1, 3, 5);
        build_expected();
        first_out = -1; last_eop = -1;
        t0 = cyc_cnt;
        drive();
        run_done(50, 1'b0);
        chk("c1_latency", DW'(first_out - t0), 2);
        chk("c1_span", DW'(last_eop - first_out), 2);

        // All four channels request together right after reset.
        do_reset();
        push_pkt(0, 2, 1); push_pkt(1, 3, 2); push_pkt(2, 1, 3); push_pkt(3, 2, 4);
        build_expected();
        gap_en = 1'b1; last_eop = -1;
        drive();
        run_done(100, 1'b0);
        gap_en = 1'b0;

        // Three-cycle MAC full mid-packet on ch2.
        push_pkt(2, 5, 4);
        build_expected();
        drive();
        repeat (3) cyc();
        pkt_tx_full = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_rdy2", DW'(samp_rdy[2]), 0);
            chk("stall_busy", DW'(busy), 1);
        end
        pkt_tx_full = 1'b0;
        run_done(100, 1'b0);

        // Stray word on ch3 while idle, then clear; then set-beats-clear.
        push_stray(3);
        drive();
        cyc();
        chk("stray_taken", DW'(src_q[3].size()), 0);
        chk("stray_err", DW'(err_sticky), 4'b1000);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("err_cleared", DW'(err_sticky), 0);
        push_stray(3);
        drive();
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("err_set_wins", DW'(err_sticky), 4'b1000);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // Reset during word 2 of a 5-word ch0 packet.
        push_pkt(0, 5, 6);
        build_expected();
        drive();
        cyc();
        cyc();
        chk("pre_rst_val", DW'(pkt_tx_val), 1);
        #2 rst = 1'b1;
        #1 chk_quiet("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        drive();
        repeat (4) cyc();
        chk("rst_drop", DW'(src_q[0].size()), 0);
        chk("rst_err", DW'(err_sticky), 4'b0001);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // Ch1 single-word packet, then ch0/ch2 contend: pointer now at 2.
        push_pkt(1, 1, 0);
        build_expected();
        drive();
        run_done(50, 1'b0);
        push_pkt(0, 2, 3); push_pkt(2, 2, 6);
        build_expected();
        drive();
        cyc();
        chk("ptr2_cur", DW'(cur_ch), 2);
        chk("ptr2_busy", DW'(busy), 1);
        run_done(50, 1'b0);

        // sop inside an open packet is forwarded and flagged.
        push_pkt(1, 3, 2);
        w = src_q[1][1];
        w.sop = 1'b1;
        src_q[1][1] = w;
        build_expected();
        drive();
        run_done(50, 1'b0);
        chk("midsop_err", DW'(err_sticky), 4'b0010);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;

        // Random packet mixes with random back-pressure.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NCH; c++) begin
                int np;
                np = $urandom_range(0, 3);
                for (int k = 0; k < np; k++)
                    push_pkt(c, $urandom_range(1, 4), $urandom_range(0, 7));
            end
            build_expected();
            drive();
            run_done(2000, 1'b1);
        end
        chk("rand_err", DW'(err_sticky), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
